// File: rtl/wb_regfile.sv
// MIPS write-back stage and 32-entry architectural register file with a saturating commit counter.
// Optional macro REGFILE_BYPASS_EN: read ports return the in-flight write-back value (write-through).
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] MemReadDataIn,
  input  logic [DATA_WIDTH-1:0] ALUResultIn,
  input  logic [ADDR_WIDTH-1:0] rdIn,
  input  logic                  MemToRegIn,
  input  logic                  RegWriteIn,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [DATA_WIDTH-1:0] WBDataOut,
  output logic                  WBValidOut,
  output logic [CNT_WIDTH-1:0]  WBCount
);

  localparam int NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NumRegs];
  logic [DATA_WIDTH-1:0] wbData;
  logic                  wbValid;
  logic [CNT_WIDTH-1:0]  wbCountR;

  // Write-back mux and commit qualifier; writes to $0 never commit.
  always_comb begin
    if (MemToRegIn) begin
      wbData = MemReadDataIn;
    end else begin
      wbData = ALUResultIn;
    end
    wbValid = RegWriteIn && (rdIn != {ADDR_WIDTH{1'b0}});
  end

  // One read port: $0 is forced to zero regardless of array contents.
  function automatic logic [DATA_WIDTH-1:0] readPort(
    input logic [ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  valid,
    input logic [ADDR_WIDTH-1:0] rd,
    input logic [DATA_WIDTH-1:0] data
  );
    logic [DATA_WIDTH-1:0] result;
    if (idx == {ADDR_WIDTH{1'b0}}) begin
      result = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (valid && (idx == rd)) begin
      result = data;
`endif
    end else begin
      result = stored;
    end
    return result;
  endfunction

  // Combinational read ports.
  always_comb begin
    ReadData1 = readPort(ReadReg1, regs[ReadReg1], wbValid, rdIn, wbData);
    ReadData2 = readPort(ReadReg2, regs[ReadReg2], wbValid, rdIn, wbData);
  end

  // Register array; reset clears every entry, including $0.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wbValid) begin
      regs[rdIn] <= wbData;
    end else begin
      regs[rdIn] <= regs[rdIn];
    end
  end

  // Committed-write counter, saturating at all-ones.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wbCountR <= {CNT_WIDTH{1'b0}};
    end else if (wbValid && (wbCountR != {CNT_WIDTH{1'b1}})) begin
      wbCountR <= wbCountR + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      wbCountR <= wbCountR;
    end
  end

  assign WBDataOut  = wbData;
  assign WBValidOut = wbValid;
  assign WBCount    = wbCountR;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file for the 5-stage MIPS pipeline.
- Sits at the far end of the MEM/WB pipeline register and consumes its outputs.
- Selects memory read data or the ALU result, commits it to the 32-entry register file, and serves the two ID-stage read ports.
- Also exposes the selected write-back value for forwarding, plus a saturating committed-write counter.

Parameters:
- DATA_WIDTH, 32, register and data width.
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.
- CNT_WIDTH, 16, width of the committed-write counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- MemReadDataIn  input  DATA_WIDTH  load data from MEM/WB.
- ALUResultIn  input  DATA_WIDTH  ALU result from MEM/WB.
- rdIn  input  ADDR_WIDTH  destination register from MEM/WB.
- MemToRegIn  input  1  1 selects MemReadDataIn, 0 selects ALUResultIn.
- RegWriteIn  input  1  write enable from MEM/WB.
- ReadReg1  input  ADDR_WIDTH  read port 1 index (rs).
- ReadReg2  input  ADDR_WIDTH  read port 2 index (rt).
- ReadData1  output  DATA_WIDTH  read port 1 data.
- ReadData2  output  DATA_WIDTH  read port 2 data.
- WBDataOut  output  DATA_WIDTH  selected write-back value, for the forwarding unit.
- WBValidOut  output  1  high when a write will commit on the next edge.
- WBCount  output  CNT_WIDTH  count of committed writes.

Behaviour:
- WBDataOut = MemToRegIn ? MemReadDataIn : ALUResultIn; combinational.
- WBValidOut = RegWriteIn && (rdIn != 0); combinational.
- Commit rule: on the rising edge of clk, if WBValidOut is high, regs[rdIn] <= WBDataOut.
- Register 0 is hardwired to zero:
  - writes to rdIn = 0 are dropped and are not counted;
  - reads of index 0 always return 0.
- Read ports are combinational, returning regs[ReadRegN].
- Simultaneous read and write to the same index: behaviour depends on REGFILE_BYPASS_EN (see Optional Feature).
- ReadReg1 == ReadReg2 is legal; both ports return the same value.
- Counter: on each rising edge where WBValidOut is high, WBCount increments by 1.
  - WBCount saturates at all-ones and never wraps.
- Write latency: data is visible in the register file one edge after it is presented.
- Reset (asynchronous, active-high):
  - takes effect immediately on assertion, regardless of clk;
  - all registers, including reg 0, are cleared to 0, and WBCount is cleared to 0;
  - ReadData1/2 therefore read 0 during and after reset.
- Reset mid-operation:
  - a write presented in the same cycle that Reset asserts is discarded;
  - state stays cleared while Reset is high;
  - the first commit occurs on the first rising edge with Reset low.
- Unknown or X select inputs are not supported; the bench must drive all inputs after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: internal write-through.
  - If WBValidOut is high and ReadRegN == rdIn, ReadDataN returns WBDataOut in the same cycle, before the edge.
  - Index 0 still returns 0.
  - The ID stage then needs no WB-to-ID forwarding path.
- Undefined: ReadDataN returns the stored value, which is old until the edge.
  - The hazard unit must forward WBDataOut or stall.
  - WBDataOut and WBValidOut are present in both builds.

Test Plan:
- Reset: assert Reset between edges with all registers written -> all ReadData immediately 0 and WBCount = 0; deassert -> regs remain 0.
- ALU write-back: RegWriteIn=1, MemToRegIn=0, rdIn=8, ALUResultIn=0x0000_1234, MemReadDataIn=0xDEAD_BEEF; one edge; ReadReg1=8 -> ReadData1=0x0000_1234, WBCount=1.
- Load write-back and $0: MemToRegIn=1, rdIn=9, MemReadDataIn=0xCAFE_F00D -> reg 9 = 0xCAFE_F00D; then rdIn=0, RegWriteIn=1 -> ReadData2 at index 0 = 0, WBCount unchanged, WBValidOut=0.
- Same-cycle read/write to reg 10 (old 0x1, new 0x2), read before the edge:
  - REGFILE_BYPASS_EN defined -> ReadData1 = 0x2;
  - undefined -> ReadData1 = 0x1, and 0x2 after the edge.
- Counter saturation: with CNT_WIDTH=4, perform 20 valid commits -> WBCount reaches 0xF and holds; RegWriteIn=0 cycles leave it unchanged.
- Reset mid-write: valid write to rd=5 with Reset asserted before the edge -> reg 5 = 0 after release; the next commit increments WBCount from 0 to 1.
